// File: rtl/imem_loader_if.sv
// Instruction-memory write bus driven by the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// UART boot loader: receives a length-prefixed program image and writes it into
// instruction memory word by word, holding the CPU in reset until the image is complete.
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  imem_loader_if.master      imem,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               frame_err,
  output logic               overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_LEN_LO, L_LEN_HI, L_DATA, L_WRITE, L_DONE} ld_state_t;

  rx_state_t         rx_state_q;
  logic              rx_meta_q;
  logic              rx_sync_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              byte_valid_q;
  logic              frame_err_q;

  ld_state_t         ld_state_q;
  logic [15:0]       len_q;
  logic [15:0]       wcount_q;
  logic [15:0]       wcount_d;
  logic [1:0]        idx_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              overflow_q;
  logic              in_range_s;

  assign wcount_d   = wcount_q + 16'd1;
  assign in_range_s = ((wcount_q >> ADDR_W) == 16'd0);

  // UART receiver: synchronizer, mid-bit sampling, glitch rejection, stop-bit check
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      byte_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            cnt_q      <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          // Returning to idle at mid-stop leaves room for a back-to-back start bit
          if (cnt_q == BIT_LAST) begin
            cnt_q      <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
            end else if (ld_state_q != L_DONE) begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM: length header, byte assembly, capacity-limited word writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state_q  <= L_LEN_LO;
      len_q       <= 16'd0;
      wcount_q    <= 16'd0;
      idx_q       <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (ld_state_q)
        L_LEN_LO: begin
          if (byte_valid_q) begin
            len_q[7:0] <= shift_q;
            busy_q     <= 1'b1;
            ld_state_q <= L_LEN_HI;
          end
        end
        L_LEN_HI: begin
          if (byte_valid_q) begin
            len_q[15:8] <= shift_q;
            if ({shift_q, len_q[7:0]} == 16'd0) begin
              ld_state_q  <= L_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              ld_state_q <= L_DATA;
              idx_q      <= 2'd0;
              wcount_q   <= 16'd0;
            end
          end
        end
        L_DATA: begin
          if (byte_valid_q) begin
            wdata_q[{idx_q, 3'b000} +: 8] <= shift_q;
            if (idx_q == 2'd3) begin
              ld_state_q <= L_WRITE;
              // Past capacity the word is consumed but never written; address holds
              if (in_range_s) begin
                we_q   <= 1'b1;
                addr_q <= wcount_q[ADDR_W-1:0];
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        L_WRITE: begin
          wcount_q <= wcount_d;
          idx_q    <= 2'd0;
          if (wcount_d == len_q) begin
            ld_state_q  <= L_DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            ld_state_q <= L_DATA;
          end
        end
        L_DONE: begin
          ld_state_q <= L_DONE;
        end
        default: ld_state_q <= L_LEN_LO;
      endcase
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;
  assign cpu_reset       = cpu_reset_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign frame_err       = frame_err_q;
  assign overflow        = overflow_q;

endmodule
